// File: rtl/star_collision_scan.sv
// star_collision_scan
// Sequential overlap check between the TA bounding box and NUM_STARS star
// boxes. One star is evaluated per clock. A scan reports a hit flag, the
// lowest hit index, a per-star hit mask and a hit count.
// Optional build macro: STAR_COLLISION_STICKY_EN (adds the hit_sticky
// game-over latch; otherwise hit_sticky is tied to 0).

module star_collision_scan #(
  parameter int NUM_STARS = 4,
  parameter int COORD_W   = 10,
  parameter int IDX_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [COORD_W-1:0]           TA_h,
  input  logic [COORD_W-1:0]           TA_v,
  input  logic [COORD_W-1:0]           TA_width,
  input  logic [COORD_W-1:0]           TA_height,
  input  logic [NUM_STARS*COORD_W-1:0] star_h,
  input  logic [NUM_STARS*COORD_W-1:0] star_v,
  input  logic [NUM_STARS*COORD_W-1:0] star_width,
  input  logic [NUM_STARS*COORD_W-1:0] star_height,
  input  logic [NUM_STARS-1:0]         star_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic [NUM_STARS-1:0]         hit_mask,
  output logic [IDX_W:0]               hit_count,
  output logic                         hit_sticky
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STARS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [NUM_STARS-1:0] acc_mask;

  // Latched TA box; the caller may change the TA inputs during a scan.
  logic [COORD_W-1:0] ta_h_q, ta_v_q, ta_w_q, ta_ht_q;

  // Star under evaluation this cycle, read live from the packed buses.
  logic [COORD_W-1:0] cur_h, cur_v, cur_w, cur_ht;
  logic               cur_valid;
  logic               star_hit;

  // Accumulator including this cycle's star, and the results derived from it.
  logic [NUM_STARS-1:0] mask_next;
  logic                 fin_hit;
  logic [IDX_W-1:0]     fin_idx;
  logic [CNT_W-1:0]     fin_count;

  // Select the current star and run the strict, non-wrapping overlap test.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    cur_h     = star_h[int'(idx)*COORD_W +: COORD_W];
    cur_v     = star_v[int'(idx)*COORD_W +: COORD_W];
    cur_w     = star_width[int'(idx)*COORD_W +: COORD_W];
    cur_ht    = star_height[int'(idx)*COORD_W +: COORD_W];
    cur_valid = star_valid[idx];
    // Sums carry one extra bit so a box at the right/bottom edge cannot wrap
    // around and appear to overlap a box near coordinate 0.
    star_hit = cur_valid
            && (cur_w  != '0) && (cur_ht  != '0)
            && (ta_w_q != '0) && (ta_ht_q != '0)
            && ({1'b0, ta_h_q} < ({1'b0, cur_h} + {1'b0, cur_w}))
            && (({1'b0, ta_h_q} + {1'b0, ta_w_q}) > {1'b0, cur_h})
            && ({1'b0, ta_v_q} < ({1'b0, cur_v} + {1'b0, cur_ht}))
            && (({1'b0, ta_v_q} + {1'b0, ta_ht_q}) > {1'b0, cur_v});
  end

  // Fold this cycle's result into the mask and derive flag, index and count.
  always_comb begin
    mask_next = acc_mask;
    fin_idx   = '0;
    fin_count = '0;
    for (int i = 0; i < NUM_STARS; i++) begin
      if (star_hit && (idx == IDX_W'(i))) mask_next[i] = 1'b1;
    end
    for (int i = NUM_STARS - 1; i >= 0; i--) begin
      if (mask_next[i]) fin_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_STARS; i++) begin
      fin_count = fin_count + CNT_W'(mask_next[i]);
    end
    fin_hit = |mask_next;
  end

  // Capture the TA box when a scan is accepted.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are deliberately not reset; they are
    // always written on scan acceptance before any star is evaluated.
    if (state == IDLE && start) begin
      ta_h_q  <= TA_h;
      ta_v_q  <= TA_v;
      ta_w_q  <= TA_width;
      ta_ht_q <= TA_height;
    end
  end

  // Scan FSM: step through the stars and register results on the last one.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc_mask  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      hit_mask  <= '0;
      hit_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            idx      <= '0;
            acc_mask <= '0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          acc_mask <= mask_next;
          if (idx == LAST_IDX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            hit       <= fin_hit;
            hit_idx   <= fin_idx;
            hit_mask  <= mask_next;
            hit_count <= fin_count;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STAR_COLLISION_STICKY_EN
  logic sticky_q;

  // Game-over latch: set by any completed scan that hit, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (state == SCAN && idx == LAST_IDX && fin_hit) begin
      sticky_q <= 1'b1;
    end
  end

  assign hit_sticky = sticky_q;
`else
  assign hit_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_star_collision_scan.sv
// Testbench for star_collision_scan (NUM_STARS=4, COORD_W=10).
// Directed vector table, random scans against a behavioural overlap model,
// and hand-written sequences for ignored start, back-to-back start, mid-scan
// reset and the sticky flag.

module tb_star_collision_scan;

  localparam int N  = 4;
  localparam int CW = 10;

  typedef struct packed {
    logic [CW-1:0]   ta_h;
    logic [CW-1:0]   ta_v;
    logic [CW-1:0]   ta_w;
    logic [CW-1:0]   ta_ht;
    logic [N*CW-1:0] sh;
    logic [N*CW-1:0] sv;
    logic [N*CW-1:0] sw;
    logic [N*CW-1:0] sht;
    logic [N-1:0]    valid;
    logic            exp_hit;
    logic [1:0]      exp_idx;
    logic [N-1:0]    exp_mask;
    logic [2:0]      exp_cnt;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   TA_h, TA_v, TA_width, TA_height;
  logic [N*CW-1:0] star_h, star_v, star_width, star_height;
  logic [N-1:0]    star_valid;
  logic            busy, done, hit, hit_sticky;
  logic [1:0]      hit_idx;
  logic [N-1:0]    hit_mask;
  logic [2:0]      hit_count;

  int checks   = 0;
  int failures = 0;
  logic sticky_exp = 1'b0;

  star_collision_scan #(.NUM_STARS(N), .COORD_W(CW), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .TA_h(TA_h), .TA_v(TA_v), .TA_width(TA_width), .TA_height(TA_height),
    .star_h(star_h), .star_v(star_v), .star_width(star_width),
    .star_height(star_height), .star_valid(star_valid),
    .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
    .hit_mask(hit_mask), .hit_count(hit_count), .hit_sticky(hit_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [N*CW-1:0] p4(input int a, input int b,
                                          input int c, input int d);
    p4 = {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  // Reference model: plain integer arithmetic straight from the overlap rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int th = int'(v.ta_h), tv = int'(v.ta_v), tw = int'(v.ta_w), tt = int'(v.ta_ht);
    int cnt = 0;
    bit found = 0;
    r.exp_mask = '0;
    r.exp_idx  = '0;
    for (int i = 0; i < N; i++) begin
      int h = int'(v.sh[i*CW +: CW]);
      int y = int'(v.sv[i*CW +: CW]);
      int w = int'(v.sw[i*CW +: CW]);
      int t = int'(v.sht[i*CW +: CW]);
      if (v.valid[i] && tw > 0 && tt > 0 && w > 0 && t > 0 &&
          th < h + w && th + tw > h && tv < y + t && tv + tt > y) begin
        r.exp_mask[i] = 1'b1;
        cnt++;
        if (!found) begin
          r.exp_idx = 2'(i);
          found = 1;
        end
      end
    end
    r.exp_hit = found;
    r.exp_cnt = 3'(cnt);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    TA_h = v.ta_h; TA_v = v.ta_v; TA_width = v.ta_w; TA_height = v.ta_ht;
    star_h = v.sh; star_v = v.sv; star_width = v.sw; star_height = v.sht;
    star_valid = v.valid;
  endtask

  // Pulse start for one edge and return how many edges later done appeared.
  task automatic run_scan(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    int lat;
    drive(v);
    run_scan(lat);
    check({name, " latency"}, lat, N);
    check({name, " hit"}, hit, v.exp_hit);
    check({name, " hit_idx"}, hit_idx, v.exp_idx);
    check({name, " hit_mask"}, hit_mask, v.exp_mask);
    check({name, " hit_count"}, hit_count, v.exp_cnt);
    check({name, " busy"}, busy, 0);
`ifdef STAR_COLLISION_STICKY_EN
    if (v.exp_hit) sticky_exp = 1'b1;
`endif
    check({name, " hit_sticky"}, hit_sticky, sticky_exp);
  endtask

  function automatic int rnd_coord();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(990, 1023));
    return int'($urandom_range(80, 140));
  endfunction

  vec_t vecs[7];
  vec_t rv;

  initial begin
    int lat, dones, first_done;

    // hit_idx/hit_mask/hit_count are hand-derived from the overlap rules.
    vecs[0] = '{100, 200, 16, 16, p4(300, 0, 110, 105), p4(300, 0, 210, 205),
                p4(8, 4, 8, 8), p4(8, 4, 8, 8), 4'b1111, 1, 2, 4'b1100, 2};
    vecs[1] = '{100, 200, 16, 16, p4(300, 0, 116, 105), p4(300, 0, 210, 205),
                p4(8, 4, 8, 8), p4(8, 4, 8, 8), 4'b0111, 0, 0, 4'b0000, 0};
    vecs[2] = '{1020, 200, 10, 16, p4(1, 500, 500, 500), p4(200, 500, 500, 500),
                p4(8, 8, 8, 8), p4(8, 8, 8, 8), 4'b1111, 0, 0, 4'b0000, 0};
    vecs[3] = '{1022, 200, 4, 16, p4(1020, 500, 500, 500), p4(200, 500, 500, 500),
                p4(8, 8, 8, 8), p4(8, 8, 8, 8), 4'b1111, 1, 0, 4'b0001, 1};
    vecs[4] = '{100, 200, 16, 16, p4(105, 108, 500, 500), p4(400, 204, 500, 500),
                p4(8, 4, 8, 8), p4(8, 4, 8, 8), 4'b1111, 1, 1, 4'b0010, 1};
    vecs[5] = '{100, 200, 16, 16, p4(105, 105, 105, 500), p4(205, 205, 205, 500),
                p4(0, 8, 4, 8), p4(8, 0, 4, 8), 4'b1111, 1, 2, 4'b0100, 1};
    vecs[6] = '{100, 200, 16, 16, p4(104, 104, 104, 104), p4(204, 204, 204, 204),
                p4(4, 4, 4, 4), p4(4, 4, 4, 4), 4'b1111, 1, 0, 4'b1111, 4};

    rst = 1'b1;
    start = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hit", hit, 0);
    check("reset hit_idx", hit_idx, 0);
    check("reset hit_mask", hit_mask, 0);
    check("reset hit_count", hit_count, 0);
    check("reset hit_sticky", hit_sticky, 0);

    foreach (vecs[i]) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk);
      #1 check($sformatf("vec%0d done pulse width", i), done, 0);
    end

    for (int n = 0; n < 40; n++) begin
      rv.ta_h = CW'(rnd_coord()); rv.ta_v = CW'(rnd_coord());
      rv.ta_w = CW'($urandom_range(0, 40)); rv.ta_ht = CW'($urandom_range(0, 40));
      for (int i = 0; i < N; i++) begin
        rv.sh[i*CW +: CW]  = CW'(rnd_coord());
        rv.sv[i*CW +: CW]  = CW'(rnd_coord());
        rv.sw[i*CW +: CW]  = CW'($urandom_range(0, 40));
        rv.sht[i*CW +: CW] = CW'($urandom_range(0, 40));
      end
      rv.valid = N'($urandom_range(0, 15));
      rv = model(rv);
      apply(rv, $sformatf("rand%0d", n));
    end

    // start during a scan is ignored: exactly one done, at the normal latency.
    drive(vecs[4]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    first_done = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
    end
    check("ignored start done count", dones, 1);
    check("ignored start latency", first_done, N);
    check("ignored start hit_idx", hit_idx, 1);

    // Back-to-back: start held in the done cycle is accepted.
    drive(vecs[0]);
    run_scan(lat);
    check("b2b first latency", lat, N);
    start = 1'b1;
    drive(vecs[6]);
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b busy after accept", busy, 1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b second latency", lat, N);
    check("b2b second hit_count", hit_count, 4);
    check("b2b second hit_mask", hit_mask, 4'b1111);

    // Reset two cycles into a scan clears everything and suppresses done.
    drive(vecs[0]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sticky_exp = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset hit", hit, 0);
    check("midreset hit_idx", hit_idx, 0);
    check("midreset hit_mask", hit_mask, 0);
    check("midreset hit_count", hit_count, 0);
    check("midreset hit_sticky", hit_sticky, 0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    check("midreset no done", dones, 0);

    // Sticky: a hit scan then a no-hit scan; the flag survives until rst.
    apply(vecs[0], "sticky hit scan");
    apply(vecs[1], "sticky miss scan");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sticky_exp = 1'b0;
    check("sticky cleared by rst", hit_sticky, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
